// File: rtl/dpr_stream_fifo_ctrl.sv
// Stream FIFO controller around an external dual-port RAM: port A writes, port B reads.
// A 2-entry skid buffer hides the RAM's registered read so the output is first-word-fall-through.
module dpr_stream_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready and out_valid come from registers only; flush cancels both transfers.
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt, ram_cnt_nxt;
  logic                  inflight;
  logic                  resetn_seen;
  logic [DATA_WIDTH-1:0] skid0, skid1, skid0_nxt, skid1_nxt;
  logic [1:0]            skid_cnt, skid_cnt_nxt;
  logic                  push, pop, rd_issue;
  logic [2:0]            occupancy, occ_limit;

  assign in_ready   = resetn_seen & (ram_cnt != FULL_CNT);
  assign out_valid  = (skid_cnt != 2'd0);
  assign out_data   = out_valid ? skid0 : '0;
  assign push       = in_valid & in_ready & ~flush;
  assign pop        = out_valid & out_ready & ~flush;

  // Only issue a read when the skid buffer is guaranteed a free slot on return.
  assign occupancy  = {1'b0, skid_cnt} + {2'b00, inflight};
  assign occ_limit  = 3'd2 + {2'b00, pop};
  assign rd_issue   = (ram_cnt != '0) & (occupancy < occ_limit) & ~flush;

  assign ram_we_a   = push;
  assign ram_addr_a = wr_ptr;
  assign ram_din_a  = in_data;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rd_ptr;

  assign level = {1'b0, ram_cnt} + {{(ADDR_WIDTH+1){1'b0}}, inflight}
               + {{ADDR_WIDTH{1'b0}}, skid_cnt};

  always_comb begin
    ram_cnt_nxt = ram_cnt;
    case ({push, rd_issue})
      2'b10:   ram_cnt_nxt = ram_cnt + 1'b1;
      2'b01:   ram_cnt_nxt = ram_cnt - 1'b1;
      default: ram_cnt_nxt = ram_cnt;
    endcase
  end

  // Pop shifts first, then returning RAM data lands behind whatever remains.
  always_comb begin
    skid0_nxt    = skid0;
    skid1_nxt    = skid1;
    skid_cnt_nxt = skid_cnt;
    if (pop) begin
      skid0_nxt    = skid1;
      skid_cnt_nxt = skid_cnt - 2'd1;
    end
    if (inflight) begin
      if (skid_cnt_nxt == 2'd0) skid0_nxt = ram_dout_b;
      else                      skid1_nxt = ram_dout_b;
      skid_cnt_nxt = skid_cnt_nxt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resetn_seen <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      inflight    <= 1'b0;
      skid0       <= '0;
      skid1       <= '0;
      skid_cnt    <= 2'd0;
    end else begin
      resetn_seen <= 1'b1;
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        ram_cnt  <= '0;
        inflight <= 1'b0;
        skid0    <= '0;
        skid1    <= '0;
        skid_cnt <= 2'd0;
      end else begin
        if (push)     wr_ptr <= wr_ptr + 1'b1;
        if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
        ram_cnt  <= ram_cnt_nxt;
        inflight <= rd_issue;
        skid0    <= skid0_nxt;
        skid1    <= skid1_nxt;
        skid_cnt <= skid_cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_dpr_stream_fifo_ctrl.sv
// Bench for dpr_stream_fifo_ctrl: behavioural RAM, queue-based FIFO model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dpr_stream_fifo_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW+1:0] level;
  logic          ram_we_a, ram_we_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_din_a;
  logic [DW-1:0] ram_dout_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  dpr_stream_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
    .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_dout_b(ram_dout_b)
  );

  // Behavioural dual-port RAM with registered read on port B
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    ram_dout_b <= mem[ram_addr_b];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected contents in order, with the edge index each word was pushed
  logic [DW-1:0] exp_q[$];
  int            ts_q[$];
  int            cyc = 0;
  int            pops = 0;
  bit            seen = 0;
  bit            hold = 0;
  logic [DW-1:0] hold_data = '0;

  always @(negedge resetn) begin
    exp_q.delete();
    ts_q.delete();
    seen = 0;
    hold = 0;
  end

  always @(posedge clk) begin
    if (!resetn) begin
      seen = 0;
      hold = 0;
      exp_q.delete();
      ts_q.delete();
    end else begin
      hold      = !flush && out_valid && !out_ready;
      hold_data = out_data;
      if (flush) begin
        exp_q.delete();
        ts_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(ts_q.pop_front());
          end
          pops++;
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(in_data);
          ts_q.push_back(cyc);
        end
      end
      seen = 1;
    end
    cyc++;
  end

  // Compare process: outputs against the model, mid-cycle
  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_we_a", ram_we_a, 0);
    end else begin
      chk("level", level, exp_q.size());
      chk("we_b", ram_we_b, 0);
      chk("we_a", ram_we_a, in_valid && in_ready && !flush);
      if (ram_we_a) chk("din_a", ram_din_a, in_data);
      if (!seen)                           chk("in_ready_pre", in_ready, 0);
      else if (exp_q.size() < DEPTH)       chk("in_ready_room", in_ready, 1);
      else if (exp_q.size() == DEPTH + 2)  chk("in_ready_full", in_ready, 0);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", out_valid, 0);
        else begin
          chk("head_data", out_data, exp_q[0]);
          chk("head_early", (cyc - ts_q[0]) >= 3, 1);
        end
      end else if (exp_q.size() > 0 && (cyc - ts_q[0]) >= 3) begin
        chk("head_late", out_valid, 1);
      end
      if (hold) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hold_data);
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int max);
    int k = 0;
    while (!out_valid && k < max) begin step(); k++; end
    chk(name, out_valid, 1);
  endtask

  task automatic wait_empty(input string name, input int max);
    int k = 0;
    while (level != 0 && k < max) begin step(); k++; end
    chk(name, level, 0);
  endtask

  bit prod_done;

  initial begin
    int pops_before;
    logic [DW-1:0] data_list [3];
    data_list[0] = 8'h11; data_list[1] = 8'h22; data_list[2] = 8'h33;

    #1;
    chk("init_out_valid", out_valid, 0);
    chk("init_level", level, 0);
    chk("init_in_ready", in_ready, 0);
    chk("init_out_data", out_data, 0);
    chk("init_addr_a", ram_addr_a, 0);
    chk("init_addr_b", ram_addr_b, 0);
    step(); step();
    resetn = 1'b1;
    step();

    // Back-to-back 0x11,0x22,0x33 with out_ready high
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = data_list[0];
    step();
    in_data = data_list[1];
    chk("lat_edge1", out_valid, 0);
    step();
    in_data = data_list[2];
    chk("lat_edge2", out_valid, 0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("b2b_valid", out_valid, 1);
      chk("b2b_data", out_data, data_list[i]);
      step();
    end
    chk("b2b_empty", level, 0);
    out_ready = 1'b0;

    // Flush to a known pointer origin, then fill to capacity
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_addr_a", ram_addr_a, 0);
    chk("flush_addr_b", ram_addr_b, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = DW'(i);
      step();
    end
    in_valid = 1'b0;
    chk("full_in_ready", in_ready, 0);
    chk("full_level", level, 10);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    begin
      int k = 0;
      while (!in_ready && k < 2) begin step(); k++; end
      chk("refill_ready", in_ready, 1);
    end
    out_ready = 1'b1;
    wait_empty("fill_drain", 40);
    out_ready = 1'b0;
    chk("wrap_addr_a", ram_addr_a, 2);
    chk("wrap_addr_b", ram_addr_b, 2);

    // Push and pop in the same cycle at level 1
    in_valid = 1'b1; in_data = 8'h40;
    step();
    in_valid = 1'b0;
    wait_valid("lvl1_valid", 5);
    chk("lvl1_level", level, 1);
    in_valid = 1'b1; in_data = 8'h41; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pushpop_level", level, 1);
    wait_valid("pushpop_next", 5);
    chk("pushpop_data", out_data, 8'h41);
    out_ready = 1'b1;
    wait_empty("pushpop_drain", 10);

    // Random stalls over 3*DEPTH words
    pops_before = pops;
    prod_done = 0;
    fork
      begin
        for (int i = 0; i < 3 * DEPTH; i++) begin
          int g = 0;
          in_valid = 1'b1;
          in_data = DW'($urandom_range(0, 255));
          while (!in_ready && g < 100) begin step(); g++; end
          step();
          in_valid = 1'b0;
          if ($urandom_range(0, 3) == 0) step();
        end
        prod_done = 1;
      end
      begin
        for (int c = 0; c < 600; c++) begin
          if (prod_done && level == 0) break;
          out_ready = ($urandom_range(0, 2) != 0);
          step();
        end
      end
    join
    out_ready = 1'b0;
    chk("rand_empty", level, 0);
    chk("rand_pops", pops - pops_before, 3 * DEPTH);

    // Flush with a read in flight and data in the skid buffer
    in_valid = 1'b1;
    in_data = 8'hA1; step();
    in_data = 8'hA2; step();
    in_data = 8'hA3; step();
    chk("preflush_level", level, 3);
    flush = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_level", level, 0);
    step();
    chk("flush_discard", out_valid, 0);
    in_valid = 1'b1; in_data = 8'hAB;
    step();
    in_valid = 1'b0;
    wait_valid("postflush_valid", 5);
    chk("postflush_data", out_data, 8'hAB);
    out_ready = 1'b1;
    wait_empty("postflush_drain", 10);

    // Asynchronous reset in the middle of a stream
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      step();
    end
    in_data = 8'h5A;
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_we_a", ram_we_a, 0);
    chk("arst_addr_a", ram_addr_a, 0);
    chk("arst_addr_b", ram_addr_b, 0);
    step();
    resetn = 1'b1;
    begin
      int g = 0;
      while (!in_ready && g < 5) begin step(); g++; end
      chk("arst_ready_back", in_ready, 1);
    end
    step();
    in_valid = 1'b0;
    wait_valid("arst_first_valid", 5);
    chk("arst_first_data", out_data, 8'h5A);
    wait_empty("arst_drain", 10);
    out_ready = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
